// File: rtl/dot_product_result_collector_if.sv
// Result handshake bundle between the dot-product units and the result collector.
// Handshake: unit i raises done_array[i] with result_array[i] stable and holds both until a
// rising edge where accept_array[i]=1; that edge transfers the word. A done still high on the
// following cycle presents the next result.
interface dot_product_result_collector_if #(
  parameter int NUM_UNITS    = 4,
  parameter int RESULT_WIDTH = 32
);
  logic [NUM_UNITS-1:0]                   done_array;
  logic [NUM_UNITS-1:0][RESULT_WIDTH-1:0] result_array;
  logic [NUM_UNITS-1:0]                   accept_array;

  modport master (output done_array, result_array, input accept_array);
  modport slave  (input done_array, result_array, output accept_array);
endinterface

// File: rtl/dot_product_result_collector.sv
// Write-back collector: one holding register per unit, round-robin arbitration onto a single
// write port of a per-unit result memory, plus a registered host read port.
module dot_product_result_collector #(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
  parameter int NUM_UNITS    = 4,
  parameter int DEPTH        = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int UW = $clog2(NUM_UNITS),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  dot_product_result_collector_if.slave  units,
  output logic [NUM_UNITS-1:0][CW-1:0]   count_array,
  output logic [NUM_UNITS-1:0]           full_array,
  output logic                           all_done,
  input  logic                           rd_en,
  input  logic [UW-1:0]                  rd_unit,
  input  logic [IW-1:0]                  rd_index,
  output logic [RESULT_WIDTH-1:0]        rd_data,
  output logic                           rd_valid
);

  logic [NUM_UNITS-1:0]    pending;
  logic [RESULT_WIDTH-1:0] hold [NUM_UNITS];
  logic [CW-1:0]           count [NUM_UNITS];
  logic [UW-1:0]           rr;
  logic [RESULT_WIDTH-1:0] mem [NUM_UNITS][DEPTH];

  logic [NUM_UNITS-1:0]    accept;
  logic                    grant_valid;
  logic [UW-1:0]           grant;
  logic [RESULT_WIDTH-1:0] rd_word;

  // A unit whose holding slot is busy or whose memory region is full is not accepted.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      accept[i] = units.done_array[i] & ~pending[i] &
                  (({1'b0, count[i]} + (CW+1)'(pending[i])) < (CW+1)'(DEPTH)) &
                  ~clear & reset;
    end
  end

  assign units.accept_array = accept;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!grant_valid && pending[(int'(rr) + k) % NUM_UNITS]) begin
        grant_valid = 1'b1;
        grant       = UW'((int'(rr) + k) % NUM_UNITS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      rr      <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        count[i] <= '0;
        hold[i]  <= '0;
      end
    end else if (clear) begin
      pending <= '0;
      rr      <= '0;
      for (int i = 0; i < NUM_UNITS; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (accept[i]) begin
          hold[i]    <= units.result_array[i];
          pending[i] <= 1'b1;
        end
      end
      // Accept requires an empty slot and grant requires a full one, so these never collide.
      if (grant_valid) begin
        pending[grant] <= 1'b0;
        count[grant]   <= count[grant] + CW'(1);
        rr             <= (int'(grant) == NUM_UNITS - 1) ? '0 : grant + UW'(1);
      end
    end
  end

  // A pending slot implies count < DEPTH, so the low count bits always address a free entry.
  always_ff @(posedge clk) begin
    if (grant_valid && !clear) mem[grant][count[grant][IW-1:0]] <= hold[grant];
  end

  always_comb begin
    rd_word = '0;
    if (int'(rd_unit) < NUM_UNITS) begin
      if (CW'(rd_index) < count[rd_unit]) rd_word = mem[rd_unit][rd_index];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_word;
    end
  end

  always_comb begin
    count_array = '0;
    full_array  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      count_array[i] = count[i];
      full_array[i]  = (count[i] == CW'(DEPTH));
    end
  end

  assign all_done = &full_array;

endmodule
